// File: rtl/fetch_prefetch_buffer_pkg.sv
// Shared fetch-path definitions: word size, NOP encoding and the buffered entry layout.
// Imported by the prefetch buffer top and by anything that unpacks its FIFO entries.
package fetch_prefetch_buffer_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(INSTR_BYTES - 1));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; occupancy is a separate counter so full and empty
// are distinguishable while the pointers simply wrap.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             push_en;
    logic             pop_en;

    // Flush wins over both push and pop issued in the same cycle.
    assign push_en = push && !flush && (occ_q != FULL_OCC);
    assign pop_en  = pop && !flush && (occ_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_en, pop_en})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata     = mem_q[rd_ptr_q];
    assign occupancy = occ_q;

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Instruction-fetch front end: issues sequential imem reads, buffers returned words with
// their PC, hands them to decode over valid/ready, and flushes/restarts on redirect.
module fetch_prefetch_buffer
    import fetch_prefetch_buffer_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         imem_req,
    output logic [XLEN-1:0]              imem_addr,
    input  logic [XLEN-1:0]              imem_rdata,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         out_valid,
    output logic [XLEN-1:0]              out_instr,
    output logic [XLEN-1:0]              out_pc,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int OCC_X = OCC_W + 1;
    localparam logic [OCC_W:0] DEPTH_X = OCC_X'(DEPTH);

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic              issue;
    logic              push;
    logic              pop;
    logic [OCC_W:0]    credit_used;
    logic [OCC_W-1:0]  occ;
    fetch_entry_t      wr_entry;
    fetch_entry_t      head_entry;
    logic [2*XLEN-1:0] wr_data;
    logic [2*XLEN-1:0] rd_data;

    // An outstanding fetch reserves a slot; a same-cycle pop earns no credit.
    assign credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q};
    assign issue       = rst_n && !redirect_valid && (credit_used < DEPTH_X);
    assign imem_req    = issue;
    assign imem_addr   = fetch_pc_q;

    assign push = inflight_q && !redirect_valid;
    assign pop  = out_valid && out_ready;

    assign wr_entry.instr = imem_rdata;
    assign wr_entry.pc    = inflight_pc_q;
    assign wr_data        = wr_entry;
    assign head_entry     = rd_data;

    sync_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .wdata     (wr_data),
        .rdata     (rd_data),
        .occupancy (occ)
    );

    // Head fields read as zero when empty so stale storage never leaks out.
    assign out_valid = (occ != '0);
    assign out_instr = out_valid ? head_entry.instr : '0;
    assign out_pc    = out_valid ? head_entry.pc : '0;
    assign occupancy = occ;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = align_word(redirect_pc);
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + XLEN'(INSTR_BYTES);
            inflight_pc_d = fetch_pc_q;
            inflight_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer: a per-cycle vector table for streaming and
// back-pressure, then hand-written sequences for redirect, wrap and mid-stream reset.
module tb_fetch_prefetch_buffer;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [2:0]  occ;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready = 1'b0;
    logic [2:0]  occupancy;

    int n_vec = 0;
    int n_err = 0;

    fetch_prefetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // imem: one-cycle registered read
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= word(imem_addr);
    end

    always @(negedge clk) begin
        if (rst_n && occupancy > 3'd4) begin
            n_err++;
            $display("FAIL occ_bound occupancy got %0d want <= 4", occupancy);
        end
    end

    function automatic vec_t mk(input logic r, input logic rdy, input logic rv,
                                input logic [31:0] rpc, input logic req,
                                input logic [31:0] addr, input logic v,
                                input logic [31:0] pc, input int occ);
        vec_t t;
        t.rst = r; t.rdy = rdy; t.rv = rv; t.rpc = rpc;
        t.req = req; t.addr = addr; t.valid = v; t.pc = pc; t.occ = 3'(occ);
        return t;
    endfunction

    task automatic check(input string tag, input vec_t v);
        logic [31:0] e_instr;
        e_instr = v.valid ? word(v.pc) : 32'h0;
        n_vec++;
        if (imem_req !== v.req) begin
            n_err++; $display("FAIL %s imem_req got %0b want %0b", tag, imem_req, v.req);
        end
        if (imem_addr !== v.addr) begin
            n_err++; $display("FAIL %s imem_addr got %h want %h", tag, imem_addr, v.addr);
        end
        if (out_valid !== v.valid) begin
            n_err++; $display("FAIL %s out_valid got %0b want %0b", tag, out_valid, v.valid);
        end
        if (out_pc !== v.pc) begin
            n_err++; $display("FAIL %s out_pc got %h want %h", tag, out_pc, v.pc);
        end
        if (out_instr !== e_instr) begin
            n_err++; $display("FAIL %s out_instr got %h want %h", tag, out_instr, e_instr);
        end
        if (occupancy !== v.occ) begin
            n_err++; $display("FAIL %s occupancy got %0d want %0d", tag, occupancy, v.occ);
        end
    endtask

    task automatic cyc(input string tag, input vec_t v);
        rst_n          = v.rst;
        out_ready      = v.rdy;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        @(negedge clk);
        check(tag, v);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t tbl[23];

    initial begin
        // Streaming with out_ready=1, then reset and 10 cycles of back-pressure, then release.
        tbl[0]  = mk(0, 1, 0, 0,  0, 0,  0, 0,  0);
        tbl[1]  = mk(1, 1, 0, 0,  1, 0,  0, 0,  0);
        tbl[2]  = mk(1, 1, 0, 0,  1, 4,  0, 0,  0);
        tbl[3]  = mk(1, 1, 0, 0,  1, 8,  1, 0,  1);
        tbl[4]  = mk(1, 1, 0, 0,  1, 12, 1, 4,  1);
        tbl[5]  = mk(1, 1, 0, 0,  1, 16, 1, 8,  1);
        tbl[6]  = mk(0, 0, 0, 0,  0, 20, 1, 12, 1);
        tbl[7]  = mk(1, 0, 0, 0,  1, 0,  0, 0,  0);
        tbl[8]  = mk(1, 0, 0, 0,  1, 4,  0, 0,  0);
        tbl[9]  = mk(1, 0, 0, 0,  1, 8,  1, 0,  1);
        tbl[10] = mk(1, 0, 0, 0,  1, 12, 1, 0,  2);
        tbl[11] = mk(1, 0, 0, 0,  0, 16, 1, 0,  3);
        for (int i = 12; i <= 16; i++) tbl[i] = mk(1, 0, 0, 0, 0, 16, 1, 0, 4);
        tbl[17] = mk(1, 1, 0, 0,  0, 16, 1, 0,  4);
        tbl[18] = mk(1, 1, 0, 0,  1, 16, 1, 4,  3);
        tbl[19] = mk(1, 1, 0, 0,  1, 20, 1, 8,  2);
        tbl[20] = mk(1, 1, 0, 0,  1, 24, 1, 12, 2);
        tbl[21] = mk(1, 1, 0, 0,  1, 28, 1, 16, 2);
        tbl[22] = mk(1, 1, 0, 0,  1, 32, 1, 20, 2);

        reset_dut();
        for (int i = 0; i < 23; i++) cyc($sformatf("tbl[%0d]", i), tbl[i]);

        // Redirect with 3 buffered entries and one fetch in flight.
        reset_dut();
        cyc("rd_fill0", mk(1, 0, 0, 0,          1, 0,      0, 0,     0));
        cyc("rd_fill1", mk(1, 0, 0, 0,          1, 4,      0, 0,     0));
        cyc("rd_fill2", mk(1, 0, 0, 0,          1, 8,      1, 0,     1));
        cyc("rd_fill3", mk(1, 0, 0, 0,          1, 12,     1, 0,     2));
        cyc("rd_hit",   mk(1, 0, 1, 32'h100,    0, 16,     1, 0,     3));
        cyc("rd_flush", mk(1, 1, 0, 0,          1, 32'h100, 0, 0,    0));
        cyc("rd_wait",  mk(1, 1, 0, 0,          1, 32'h104, 0, 0,    0));
        cyc("rd_first", mk(1, 1, 0, 0,          1, 32'h108, 1, 32'h100, 1));
        cyc("rd_next1", mk(1, 1, 0, 0,          1, 32'h10C, 1, 32'h104, 1));
        cyc("rd_next2", mk(1, 1, 0, 0,          1, 32'h110, 1, 32'h108, 1));

        // Misaligned redirect target, then back-to-back redirects.
        cyc("mis_hit",  mk(1, 1, 1, 32'h203,    0, 32'h114, 1, 32'h10C, 1));
        cyc("mis_rst0", mk(1, 1, 0, 0,          1, 32'h200, 0, 0,    0));
        cyc("mis_rst1", mk(1, 1, 0, 0,          1, 32'h204, 0, 0,    0));
        cyc("mis_out",  mk(1, 1, 0, 0,          1, 32'h208, 1, 32'h200, 1));
        cyc("b2b_a",    mk(1, 1, 1, 32'h40,     0, 32'h20C, 1, 32'h204, 1));
        cyc("b2b_b",    mk(1, 1, 1, 32'h80,     0, 32'h40,  0, 0,    0));
        cyc("b2b_req",  mk(1, 1, 0, 0,          1, 32'h80,  0, 0,    0));
        cyc("b2b_wait", mk(1, 1, 0, 0,          1, 32'h84,  0, 0,    0));
        cyc("b2b_out0", mk(1, 1, 0, 0,          1, 32'h88,  1, 32'h80, 1));
        cyc("b2b_out1", mk(1, 1, 0, 0,          1, 32'h8C,  1, 32'h84, 1));

        // Fetch PC wraps past the top of the address space.
        cyc("wrap_hit", mk(1, 1, 1, 32'hFFFF_FFFC, 0, 32'h90, 1, 32'h88, 1));
        cyc("wrap_top", mk(1, 1, 0, 0,          1, 32'hFFFF_FFFC, 0, 0, 0));
        cyc("wrap_0",   mk(1, 1, 0, 0,          1, 32'h0,   0, 0,    0));
        cyc("wrap_o1",  mk(1, 1, 0, 0,          1, 32'h4,   1, 32'hFFFF_FFFC, 1));
        cyc("wrap_o2",  mk(1, 1, 0, 0,          1, 32'h8,   1, 32'h0, 1));
        cyc("wrap_o3",  mk(1, 1, 0, 0,          1, 32'hC,   1, 32'h4, 1));

        // Reset mid-stream with two entries buffered.
        cyc("mrst_fill", mk(1, 0, 0, 0,         1, 32'h10,  1, 32'h8, 1));
        cyc("mrst_hit",  mk(0, 0, 0, 0,         0, 32'h14,  1, 32'h8, 2));
        cyc("mrst_post", mk(1, 1, 0, 0,         1, 32'h0,   0, 0,    0));
        cyc("mrst_req1", mk(1, 1, 0, 0,         1, 32'h4,   0, 0,    0));
        cyc("mrst_out",  mk(1, 1, 0, 0,         1, 32'h8,   1, 32'h0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
